// File: rtl/scr1_mem_arb2.sv
// scr1_mem_arb2: shares one scr1 memif target port between two masters, one outstanding transaction
module scr1_mem_arb2 #(
   parameter int AWIDTH     = 32,
   parameter int DWIDTH     = 32,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   output logic              m0_req_ack,
   input  logic              m0_cmd,
   input  logic [1:0]        m0_width,
   input  logic [AWIDTH-1:0] m0_addr,
   input  logic [DWIDTH-1:0] m0_wdata,
   output logic [DWIDTH-1:0] m0_rdata,
   output logic [1:0]        m0_resp,
   input  logic              m1_req,
   output logic              m1_req_ack,
   input  logic              m1_cmd,
   input  logic [1:0]        m1_width,
   input  logic [AWIDTH-1:0] m1_addr,
   input  logic [DWIDTH-1:0] m1_wdata,
   output logic [DWIDTH-1:0] m1_rdata,
   output logic [1:0]        m1_resp,
   output logic              s_req,
   input  logic              s_req_ack,
   output logic              s_cmd,
   output logic [1:0]        s_width,
   output logic [AWIDTH-1:0] s_addr,
   output logic [DWIDTH-1:0] s_wdata,
   input  logic [DWIDTH-1:0] s_rdata,
   input  logic [1:0]        s_resp
);
   localparam logic [1:0] RESP_NOTRDY = 2'd0;
   localparam logic [1:0] RESP_RDY_OK = 2'd1;
   typedef enum logic {ADDR, DATA} state_e;
   state_e fsm;
   logic owner_r, rr_last_r, lock_r, lock_gnt_r;
   logic window, gnt, gnt_req, accept;
   always_comb begin
      window     = (fsm == ADDR) | (s_resp == RESP_RDY_OK);
      gnt        = lock_r ? lock_gnt_r : (m0_req & m1_req) ? (FIXED_PRIO ? 1'b0 : ~rr_last_r) : m1_req;
      gnt_req    = gnt ? m1_req : m0_req;
      s_req      = ~rst & window & (m0_req | m1_req);
      accept     = s_req & s_req_ack;
      s_cmd      = gnt ? m1_cmd : m0_cmd;
      s_width    = gnt ? m1_width : m0_width;
      s_addr     = gnt ? m1_addr : m0_addr;
      s_wdata    = gnt ? m1_wdata : m0_wdata;
      m0_req_ack = accept & ~gnt;
      m1_req_ack = accept & gnt;
      m0_rdata   = s_rdata;
      m1_rdata   = s_rdata;
      m0_resp    = (fsm == DATA && !owner_r) ? s_resp : RESP_NOTRDY;
      m1_resp    = (fsm == DATA && owner_r) ? s_resp : RESP_NOTRDY;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm        <= ADDR;
         owner_r    <= 1'b0;
         rr_last_r  <= 1'b1;
         lock_r     <= 1'b0;
         lock_gnt_r <= 1'b0;
      end else if (accept) begin
         fsm        <= DATA;
         owner_r    <= gnt;
         rr_last_r  <= gnt;
         lock_r     <= 1'b0;
      end else begin
         if (fsm == DATA && s_resp != RESP_NOTRDY) fsm <= ADDR;
         // a stalled address phase keeps its grant until the requester is acked or drops
         lock_r <= (s_req | lock_r) & gnt_req;
         if (s_req) lock_gnt_r <= gnt;
      end
   end
   a_req_known: assert property (@(posedge clk) disable iff (rst) s_req |-> !$isunknown({s_cmd, s_addr}));
   a_no_resp_idle: assert property (@(posedge clk) disable iff (rst) fsm == ADDR |-> s_resp == RESP_NOTRDY);
endmodule

// File: tb/tb_scr1_mem_arb2.sv
// tb_scr1_mem_arb2: random masters and target against a queue-based scoreboard, plus directed cases
module tb_scr1_mem_arb2;
   localparam logic [1:0] NOTRDY = 2'd0, OK = 2'd1, ER = 2'd2;
   typedef struct packed {logic cmd; logic [1:0] width; logic [31:0] addr; logic [31:0] wdata;} txn_t;
   typedef struct packed {logic owner; logic [1:0] resp;} rsp_t;
   logic clk = 1'b0, rst = 1'b1;
   logic m_req [2], m_cmd [2];
   logic [1:0] m_width [2];
   logic [31:0] m_addr [2], m_wdata [2];
   logic m0_ack, m1_ack, s_req, s_cmd, s_req_ack;
   logic [1:0] m0_resp, m1_resp, s_width, s_resp;
   logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
   logic fp_req0, fp_req1, fp_ack0, fp_ack1, fp_sreq, fp_scmd, fp_acc;
   logic [1:0] fp_resp, fp_r0, fp_r1, fp_swidth;
   logic [31:0] fp_rd0, fp_rd1, fp_saddr, fp_swdata;
   txn_t mq0[$], mq1[$];
   rsp_t rq[$];
   int glog[$];
   logic [31:0] alog[$];
   logic [1:0] r0log[$];
   int tests = 0, fails = 0;
   int p_req [2], p_ack, max_wait, p_err, wait_left;
   bit rd_only, fixed_wait, busy, last, pend_v, pend_g, acc_seen, acc_g, done_seen;
   bit [1:0] ackd;
   logic [1:0] kind;
   logic g, sreq_e;
   txn_t t;
   rsp_t r;

   scr1_mem_arb2 #(.AWIDTH(32), .DWIDTH(32), .FIXED_PRIO(1'b0)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m_req[0]), .m0_req_ack(m0_ack), .m0_cmd(m_cmd[0]), .m0_width(m_width[0]),
      .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
      .m1_req(m_req[1]), .m1_req_ack(m1_ack), .m1_cmd(m_cmd[1]), .m1_width(m_width[1]),
      .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
      .s_req(s_req), .s_req_ack(s_req_ack), .s_cmd(s_cmd), .s_width(s_width), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_rdata(s_rdata), .s_resp(s_resp));

   scr1_mem_arb2 #(.AWIDTH(32), .DWIDTH(32), .FIXED_PRIO(1'b1)) u_fp (
      .clk(clk), .rst(rst),
      .m0_req(fp_req0), .m0_req_ack(fp_ack0), .m0_cmd(1'b0), .m0_width(2'd2),
      .m0_addr(32'h100), .m0_wdata(32'h0), .m0_rdata(fp_rd0), .m0_resp(fp_r0),
      .m1_req(fp_req1), .m1_req_ack(fp_ack1), .m1_cmd(1'b0), .m1_width(2'd2),
      .m1_addr(32'h200), .m1_wdata(32'h0), .m1_rdata(fp_rd1), .m1_resp(fp_r1),
      .s_req(fp_sreq), .s_req_ack(1'b1), .s_cmd(fp_scmd), .s_width(fp_swidth), .s_addr(fp_saddr),
      .s_wdata(fp_swdata), .s_rdata(32'h0), .s_resp(fp_resp));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic issue(input int n, output logic [31:0] a);
      txn_t x;
      x.cmd = rd_only ? 1'b0 : 1'($urandom_range(1));
      x.width = 2'($urandom_range(2));
      x.addr = $urandom;
      x.wdata = $urandom;
      m_req[n] = 1'b1; m_cmd[n] = x.cmd; m_width[n] = x.width; m_addr[n] = x.addr; m_wdata[n] = x.wdata;
      if (n == 0) mq0.push_back(x); else mq1.push_back(x);
      a = x.addr;
   endtask

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic quiet();
      p_req[0] = 0; p_req[1] = 0; p_ack = 100;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (!m_req[0] && !m_req[1] && !busy) return;
      end
      tests++; fails++;
      $display("FAIL drain: bus still busy after 200 cycles");
   endtask

   // masters: hold each request until acked, then maybe issue the next one in the same cycle
   initial forever begin
      logic [31:0] dummy;
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
         if (rst) m_req[n] = 1'b0;
         else begin
            if (m_req[n] && ackd[n]) m_req[n] = 1'b0;
            if (!m_req[n] && $urandom_range(99) < p_req[n]) issue(n, dummy);
         end
      end
      if (rst) begin mq0.delete(); mq1.delete(); end
   end

   // target: plans each response (wait length, OK/ER) at acceptance and queues it for the monitor
   initial forever begin
      @(posedge clk); #1;
      if (rst) begin busy = 0; rq.delete(); end
      else begin
         if (done_seen) busy = 0;
         else if (busy) wait_left--;
         if (acc_seen) begin
            busy = 1;
            wait_left = fixed_wait ? max_wait : int'($urandom_range(max_wait));
            kind = ($urandom_range(99) < p_err) ? ER : OK;
            rq.push_back('{acc_g, kind});
         end
      end
      s_resp = (busy && wait_left == 0) ? kind : NOTRDY;
      s_rdata = $urandom;
      s_req_ack = $urandom_range(99) < p_ack;
   end

   // zero-wait OK target for the fixed-priority instance
   initial forever begin
      @(negedge clk); fp_acc = fp_sreq && !rst;
      @(posedge clk); #1; fp_resp = (fp_acc && !rst) ? OK : NOTRDY;
   end

   // monitor: expected grant from the arbitration rules, expected payload/response from the queues
   initial forever begin
      @(negedge clk);
      acc_seen = 0; done_seen = 0; ackd = '0;
      if (rst) begin last = 1; pend_v = 0; end
      else begin
         g = pend_v ? pend_g : (m_req[0] && m_req[1]) ? !last : m_req[1];
         sreq_e = (m_req[0] || m_req[1]) && (!busy || s_resp == OK);
         check("s_req", s_req, sreq_e);
         check("m0_req_ack", m0_ack, sreq_e && s_req_ack && !g);
         check("m1_req_ack", m1_ack, sreq_e && s_req_ack && g);
         if (sreq_e) begin
            t = g ? mq1[0] : mq0[0];
            check("s_addr", s_addr, t.addr);
            check("s_cmd", s_cmd, t.cmd);
            check("s_width", s_width, t.width);
            check("s_wdata", s_wdata, t.wdata);
         end
         if (busy) begin
            r = rq[0];
            check("owner_resp", r.owner ? m1_resp : m0_resp, wait_left == 0 ? r.resp : NOTRDY);
            check("other_resp", r.owner ? m0_resp : m1_resp, NOTRDY);
            if (wait_left == 0) begin done_seen = 1; void'(rq.pop_front()); end
         end else begin
            check("idle_m0_resp", m0_resp, NOTRDY);
            check("idle_m1_resp", m1_resp, NOTRDY);
         end
         check("rdata", {m0_rdata, m1_rdata}, {s_rdata, s_rdata});
         glog.push_back(m1_ack ? 1 : m0_ack ? 0 : -1);
         alog.push_back(s_addr);
         r0log.push_back(m0_resp);
         if (sreq_e && s_req_ack) begin
            acc_seen = 1; acc_g = g; ackd[g] = 1'b1; last = g; pend_v = 0;
            if (g) void'(mq1.pop_front()); else void'(mq0.pop_front());
         end else if (sreq_e) begin
            pend_v = 1; pend_g = g;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n0, n1, first;
      logic [31:0] a0, a1;
      m_req[0] = 0; m_req[1] = 0;
      for (int n = 0; n < 2; n++) begin m_cmd[n] = 0; m_width[n] = 0; m_addr[n] = 0; m_wdata[n] = 0; end
      fp_req0 = 0; fp_req1 = 0; fp_resp = NOTRDY; fp_acc = 0;
      s_req_ack = 0; s_resp = NOTRDY; s_rdata = 0; busy = 0; wait_left = 0; kind = NOTRDY;
      p_req[0] = 0; p_req[1] = 0; p_ack = 100; max_wait = 0; p_err = 0; rd_only = 0; fixed_wait = 0;
      #2 m_req[0] = 1;
      #1;
      check("rst_s_req", s_req, 0);
      check("rst_acks", {m0_ack, m1_ack}, 0);
      check("rst_resps", {m0_resp, m1_resp}, {NOTRDY, NOTRDY});
      m_req[0] = 0;
      // round robin from reset, both requesting continuously
      p_req[0] = 100; p_req[1] = 100;
      tick(); tick();
      rst = 0;
      base = glog.size();
      repeat (8) tick();
      n0 = 0;
      for (int i = base; i < glog.size() && n0 < 4; i++)
         if (glog[i] >= 0) begin check($sformatf("rr_grant%0d", n0), glog[i], n0 % 2); n0++; end
      check("rr_grant_count", n0, 4);
      quiet();
      // m0 alone, back-to-back reads with a zero-wait target
      rd_only = 1; p_req[0] = 100;
      base = glog.size();
      repeat (6) tick();
      for (int i = 1; i <= 4; i++) check($sformatf("m0_b2b%0d", i), glog[base + i], 0);
      quiet();
      rd_only = 0;
      // m1 stalled by target, m0 arrives later and must not preempt
      p_ack = 0; tick();
      issue(1, a1); base = glog.size(); tick();
      issue(0, a0); tick();
      p_ack = 100; tick(); tick(); tick();
      for (int i = 0; i < 3; i++) check($sformatf("stall_noack%0d", i), glog[base + i], -1);
      for (int i = 1; i < 4; i++) check($sformatf("stall_addr%0d", i), alog[base + i], a1);
      check("stall_m1_ack", glog[base + 3], 1);
      check("stall_m0_next", glog[base + 4], 0);
      quiet();
      // error response blocks the pipelined accept for that cycle
      fixed_wait = 1; max_wait = 1; p_err = 100;
      issue(0, a0); base = glog.size(); tick();
      issue(1, a1); p_err = 0; tick(); tick(); tick();
      check("er_m0_ack", glog[base], 0);
      check("er_resp", r0log[base + 2], ER);
      check("er_no_ack", glog[base + 2], -1);
      check("er_m1_after", glog[base + 3], 1);
      quiet();
      fixed_wait = 0;
      // randomized traffic
      p_req[0] = 60; p_req[1] = 60; p_ack = 70; max_wait = 3; p_err = 15;
      repeat (3000) tick();
      quiet();
      // asynchronous reset while a transaction waits in DATA
      p_req[0] = 50; p_req[1] = 50; p_ack = 80; first = 0;
      for (int i = 0; i < 200 && !first; i++) begin tick(); if (busy && wait_left > 0) first = 1; end
      check("mid_rst_reached", first, 1);
      #1 rst = 1;
      #1;
      check("mid_rst_s_req", s_req, 0);
      check("mid_rst_acks", {m0_ack, m1_ack}, 0);
      check("mid_rst_resps", {m0_resp, m1_resp}, {NOTRDY, NOTRDY});
      p_req[0] = 100; p_req[1] = 100; p_ack = 100; max_wait = 0; p_err = 0;
      tick(); tick();
      rst = 0; base = glog.size();
      repeat (4) tick();
      first = -1;
      for (int i = base; i < glog.size(); i++) if (first < 0 && glog[i] >= 0) first = glog[i];
      check("post_rst_first", first, 0);
      quiet();
      // fixed priority: m1 starved while m0 keeps requesting
      fp_req0 = 1; fp_req1 = 1; n0 = 0; n1 = 0;
      repeat (10) begin @(negedge clk); n0 += int'(fp_ack0); n1 += int'(fp_ack1); end
      check("fp_m1_starved", n1, 0);
      check("fp_m0_acks", n0, 10);
      tick(); fp_req0 = 0;
      @(negedge clk);
      check("fp_m1_gnt", fp_ack1, 1);
      check("fp_m0_none", fp_ack0, 0);
      check("fp_s_addr", fp_saddr, 32'h200);
      tick(); fp_req1 = 0;
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
